sc_spil_sce: RTL and testbench
==============================

SC_SPIL_SCE -- requirements
Module: sc_spil_sce

Interface
REQ-001 SHALL have parameter NUM_OF_CS, default 32, meaning number of active-low chip-select inputs (legal 1..32).
REQ-002 SHALL have parameter FILT_LEN, default 2, meaning consecutive stable cycles required before a CS pattern is accepted (legal 1..15).
REQ-003 SHALL have port CLK  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port CSB_IN  input  NUM_OF_CS  active-low chip selects, asynchronous to CLK.
REQ-006 SHALL have port ERR_CLR  input  1  synchronous clear of the sticky CS_ERR flag.
REQ-007 SHALL have port CS_SEL  output  5  index of the currently or last selected CS line; bits above the index range are 0.
REQ-008 SHALL have port CS_ACT  output  1  high while exactly one legal CS line is selected.
REQ-009 SHALL have port CS_START  output  1  one-cycle pulse at the start of a selection.
REQ-010 SHALL have port CS_END  output  1  one-cycle pulse at the end of a selection.
REQ-011 SHALL have port CS_ERR  output  1  sticky flag for a multi-select or a direct switch between lines.
REQ-012 SHALL have port TXN_CNT  output  16  count of accepted selections.

Function
REQ-013 SHALL pass each CSB_IN bit through a 2-flop synchronizer; the flops reset to 1.
REQ-014 SHALL hold a filtered vector, reset all-ones, updated to the synchronizer output only after that output has been unchanged for FILT_LEN consecutive cycles.
REQ-015 SHALL restart the stability count on any bit change, so a pulse shorter than FILT_LEN cycles never reaches the filtered vector.
REQ-016 SHALL classify the filtered vector each cycle: NONE (all 1s), SINGLE(i) (exactly bit i low), or MULTI (two or more bits low).
REQ-017 SHALL implement FSM states IDLE, ACTIVE, and FAULT; the reset state is IDLE.
REQ-018 IDLE: SINGLE(i) -> ACTIVE, latch CS_SEL=i, pulse CS_START, TXN_CNT+1; MULTI -> FAULT, set CS_ERR; NONE -> stay.
REQ-019 ACTIVE: SINGLE(same i) -> stay; NONE -> IDLE with CS_END pulse; SINGLE(j != i) or MULTI -> FAULT with CS_END pulse, set CS_ERR.
REQ-020 FAULT: stay until NONE, then -> IDLE with no pulse; CS_START is never issued from FAULT.
REQ-021 SHALL drive CS_ACT high exactly while the state is ACTIVE; outputs are registered.
REQ-022 SHALL assert CS_START exactly FILT_LEN+3 CLK cycles after the first edge that samples a new CSB_IN value; CS_END has the same latency.
REQ-023 SHALL hold CS_SEL at its last latched value in IDLE and FAULT; it changes only on an IDLE->ACTIVE transition.
REQ-024 SHALL keep CS_ERR set until ERR_CLR=1; when an error event and ERR_CLR occur in the same cycle, set wins.
REQ-025 SHALL make TXN_CNT a 16-bit counter that wraps 0xFFFF -> 0x0000 without a flag.
REQ-026 SHALL ignore CSB_IN bits at or above NUM_OF_CS (not present); NUM_OF_CS=1 yields CS_SEL=0 always.

Reset
REQ-027 On RESET=1, SHALL immediately set: synchronizers and filtered vector to all 1s, state to IDLE, CS_SEL=0, CS_ACT=0, CS_START=0, CS_END=0, CS_ERR=0, TXN_CNT=0, stability count=0.
REQ-028 SHALL emit no CS_END for a selection aborted by reset; after release, a CS held low is accepted as a fresh selection after FILT_LEN+3 cycles.

Verification
REQ-029 FILT_LEN=2, CSB_IN[5] low for 20 cycles -> CS_START at cycle 5, CS_SEL=5, CS_ACT=1, TXN_CNT=1; CS_END 5 cycles after release.
REQ-030 CSB_IN[3] low for 1 cycle (glitch) -> no CS_START, CS_ACT stays 0, TXN_CNT unchanged.
REQ-031 CSB_IN[1] and CSB_IN[7] low together -> CS_ERR=1, CS_ACT=0, no CS_START; after release and ERR_CLR, CS_ERR=0.
REQ-032 While ACTIVE on 2, switch directly to 4 -> CS_END pulse, CS_ERR=1, state FAULT; no CS_START until all lines go high and 4 reasserts.
REQ-033 Preload 0xFFFF selections (or force) then one more selection -> TXN_CNT=0x0000.
REQ-034 Assert RESET mid-selection on line 9 -> outputs at reset values at once, no CS_END; with CSB_IN[9] still low after release, CS_START at cycle FILT_LEN+3.

Source files
------------

// File: rtl/sc_spil_sce_if.sv
// sc_spil_sce_if: bus between a chip-select monitor and its environment.
// master drives CSB_IN/ERR_CLR and observes the status; slave is the monitor.
interface sc_spil_sce_if #(
  parameter int NUM_OF_CS = 32
);
  logic [NUM_OF_CS-1:0] CSB_IN;
  logic                 ERR_CLR;
  logic [4:0]           CS_SEL;
  logic                 CS_ACT;
  logic                 CS_START;
  logic                 CS_END;
  logic                 CS_ERR;
  logic [15:0]          TXN_CNT;

  modport master (
    output CSB_IN,
    output ERR_CLR,
    input  CS_SEL,
    input  CS_ACT,
    input  CS_START,
    input  CS_END,
    input  CS_ERR,
    input  TXN_CNT
  );

  modport slave (
    input  CSB_IN,
    input  ERR_CLR,
    output CS_SEL,
    output CS_ACT,
    output CS_START,
    output CS_END,
    output CS_ERR,
    output TXN_CNT
  );
endinterface

// File: rtl/sc_spil_sce.sv
// sc_spil_sce: SPI chip-select monitor. Synchronizes and deglitches the
// active-low CS lines, tracks selections, flags multi/switch errors.
// Ports: CLK, RESET (async, active high), bus (slave): CSB_IN, ERR_CLR in;
// CS_SEL, CS_ACT, CS_START, CS_END, CS_ERR, TXN_CNT out (all registered).
module sc_spil_sce #(
  parameter int NUM_OF_CS = 32,
  parameter int FILT_LEN  = 2
) (
  input logic          CLK,
  input logic          RESET,
  sc_spil_sce_if.slave bus
);

  localparam logic [3:0] CNT_LIM = 4'(FILT_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_FAULT
  } state_t;

  logic [NUM_OF_CS-1:0] r_s1;
  logic [NUM_OF_CS-1:0] r_s2;
  logic [NUM_OF_CS-1:0] r_last;
  logic [NUM_OF_CS-1:0] r_filt;
  logic [3:0]           r_cnt;

  state_t      r_state;
  state_t      w_nxt;
  logic [4:0]  r_sel;
  logic        r_act;
  logic        r_start;
  logic        r_end;
  logic        r_err;
  logic [15:0] r_txn_cnt;

  logic                 w_same;
  logic [NUM_OF_CS-1:0] w_low;
  logic                 w_none;
  logic                 w_multi;
  logic                 w_single;
  logic [4:0]           w_idx;
  logic                 w_start;
  logic                 w_end;
  logic                 w_errev;

  // Two-flop synchronizer, idle level is 1.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= bus.CSB_IN;
      r_s2 <= r_s1;
    end
  end

  // Stability filter: r_cnt counts consecutive cycles the synchronized
  // vector matched its previous value; any change restarts the count.
  assign w_same = (r_s2 == r_last);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_last <= '1;
      r_cnt  <= '0;
      r_filt <= '1;
    end else begin
      r_last <= r_s2;
      if (!w_same) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_LIM) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_same && (r_cnt == CNT_LIM)) begin
        r_filt <= r_s2;
      end
    end
  end

  // Classify the filtered vector.
  assign w_low    = ~r_filt;
  assign w_none   = (w_low == '0);
  assign w_multi  = ((w_low & (w_low - 1'b1)) != '0);
  assign w_single = !w_none && !w_multi;

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_OF_CS; i++) begin
      if (w_low[i]) begin
        w_idx = 5'(i);
      end
    end
  end

  // FSM: state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // FSM: next state.
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_single) begin
          w_nxt = S_ACTIVE;
        end else if (w_multi) begin
          w_nxt = S_FAULT;
        end
      end
      S_ACTIVE: begin
        if (w_none) begin
          w_nxt = S_IDLE;
        end else if (!w_single || (w_idx != r_sel)) begin
          w_nxt = S_FAULT;
        end
      end
      S_FAULT: begin
        if (w_none) begin
          w_nxt = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // FSM: output decode (registered below).
  always_comb begin
    w_start = 1'b0;
    w_end   = 1'b0;
    w_errev = 1'b0;
    unique case (1'b1)
      (r_state == S_IDLE): begin
        w_start = w_single;
        w_errev = w_multi;
      end
      (r_state == S_ACTIVE): begin
        w_end   = (w_nxt != S_ACTIVE);
        w_errev = (w_nxt == S_FAULT);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sel   <= '0;
      r_act   <= 1'b0;
      r_start <= 1'b0;
      r_end   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_act   <= (w_nxt == S_ACTIVE);
      r_start <= w_start;
      r_end   <= w_end;
      if (w_start) begin
        r_sel <= w_idx;
      end
      // A new error wins over a simultaneous clear.
      if (w_errev) begin
        r_err <= 1'b1;
      end else if (bus.ERR_CLR) begin
        r_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_txn_cnt <= '0;
    end else if (w_start) begin
      r_txn_cnt <= r_txn_cnt + 16'd1;
    end
  end

  assign bus.CS_SEL   = r_sel;
  assign bus.CS_ACT   = r_act;
  assign bus.CS_START = r_start;
  assign bus.CS_END   = r_end;
  assign bus.CS_ERR   = r_err;
  assign bus.TXN_CNT  = r_txn_cnt;

endmodule

// File: tb/tb_sc_spil_sce.sv
// tb_sc_spil_sce: random and directed stimulus for sc_spil_sce, checked
// every cycle against a behavioural model plus literal expectations.
module tb_sc_spil_sce;
  localparam int N = 32;
  localparam int L = 2;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  int total = 0;
  int bad = 0;

  sc_spil_sce_if #(.NUM_OF_CS(N)) bus ();

  sc_spil_sce #(
    .NUM_OF_CS(N),
    .FILT_LEN (L)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Model: last L+2 sampled inputs; the filtered vector takes the value
  // two samples back once the last L+1 samples older than one agree.
  logic [N-1:0] dly [0:L+1];
  logic [N-1:0] m_filt;
  int           m_state;
  logic [4:0]   m_sel;
  logic         m_act;
  logic         m_start;
  logic         m_end;
  logic         m_err;
  logic [15:0]  m_txn;

  task automatic mreset();
    for (int k = 0; k <= L + 1; k++) dly[k] = '1;
    m_filt = '1;
    m_state = 0;
    m_sel = '0;
    m_act = 0;
    m_start = 0;
    m_end = 0;
    m_err = 0;
    m_txn = '0;
  endtask

  task automatic mstep();
    logic [N-1:0] lo;
    int nz;
    int idx;
    int ns;
    bit none;
    bit single;
    bit ev;
    bit eq;
    lo = ~m_filt;
    nz = 0;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      if (lo[i]) begin
        nz++;
        idx = i;
      end
    end
    none = (nz == 0);
    single = (nz == 1);
    m_start = 0;
    m_end = 0;
    ev = 0;
    ns = m_state;
    case (m_state)
      0: begin
        if (single) begin
          ns = 1;
          m_sel = idx[4:0];
          m_start = 1;
          m_txn = m_txn + 16'd1;
        end else if (!none) begin
          ns = 2;
          ev = 1;
        end
      end
      1: begin
        if (none) begin
          ns = 0;
          m_end = 1;
        end else if (!(single && idx == int'(m_sel))) begin
          ns = 2;
          m_end = 1;
          ev = 1;
        end
      end
      default: if (none) ns = 0;
    endcase
    m_state = ns;
    m_act = (ns == 1);
    if (ev) m_err = 1;
    else if (bus.ERR_CLR) m_err = 0;
    eq = 1;
    for (int k = 2; k <= L + 1; k++) if (dly[k] != dly[1]) eq = 0;
    if (eq) m_filt = dly[1];
    for (int k = L + 1; k >= 1; k--) dly[k] = dly[k-1];
    dly[0] = bus.CSB_IN;
  endtask

  always @(posedge CLK or posedge RESET) begin
    if (RESET) mreset();
    else mstep();
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (!RESET) begin
      chk("m_sel", 32'(bus.CS_SEL), 32'(m_sel));
      chk("m_act", 32'(bus.CS_ACT), 32'(m_act));
      chk("m_start", 32'(bus.CS_START), 32'(m_start));
      chk("m_end", 32'(bus.CS_END), 32'(m_end));
      chk("m_err", 32'(bus.CS_ERR), 32'(m_err));
      chk("m_txn", 32'(bus.TXN_CNT), 32'(m_txn));
    end
  end

  task automatic edges(int k);
    repeat (k) @(posedge CLK);
    @(negedge CLK);
  endtask

  function automatic logic [N-1:0] sel1(int i);
    logic [N-1:0] v;
    v = '1;
    v[i] = 1'b0;
    return v;
  endfunction

  initial begin
    int a;
    int b;
    int r;
    logic [N-1:0] v;
    bus.CSB_IN = '1;
    bus.ERR_CLR = 1'b0;
    edges(2);
    chk("rst_sel", 32'(bus.CS_SEL), 0);
    chk("rst_act", 32'(bus.CS_ACT), 0);
    chk("rst_err", 32'(bus.CS_ERR), 0);
    chk("rst_txn", 32'(bus.TXN_CNT), 0);
    RESET = 1'b0;
    edges(3);

    // Single selection on line 5.
    bus.CSB_IN = sel1(5);
    edges(5);
    chk("s5_nostart", 32'(bus.CS_START), 0);
    edges(1);
    chk("s5_start", 32'(bus.CS_START), 1);
    chk("s5_sel", 32'(bus.CS_SEL), 5);
    chk("s5_act", 32'(bus.CS_ACT), 1);
    chk("s5_txn", 32'(bus.TXN_CNT), 1);
    edges(1);
    chk("s5_pulse", 32'(bus.CS_START), 0);
    edges(13);
    bus.CSB_IN = '1;
    edges(5);
    chk("s5_noend", 32'(bus.CS_END), 0);
    edges(1);
    chk("s5_end", 32'(bus.CS_END), 1);
    chk("s5_idle", 32'(bus.CS_ACT), 0);
    edges(3);

    // One-cycle glitch on line 3.
    bus.CSB_IN = sel1(3);
    edges(1);
    bus.CSB_IN = '1;
    edges(10);
    chk("gl_act", 32'(bus.CS_ACT), 0);
    chk("gl_txn", 32'(bus.TXN_CNT), 1);

    // Lines 1 and 7 together.
    v = sel1(1);
    v[7] = 1'b0;
    bus.CSB_IN = v;
    edges(8);
    chk("mu_err", 32'(bus.CS_ERR), 1);
    chk("mu_act", 32'(bus.CS_ACT), 0);
    chk("mu_txn", 32'(bus.TXN_CNT), 1);
    bus.CSB_IN = '1;
    edges(6);
    bus.ERR_CLR = 1'b1;
    edges(1);
    bus.ERR_CLR = 1'b0;
    chk("mu_clr", 32'(bus.CS_ERR), 0);

    // Direct switch from line 2 to line 4.
    bus.CSB_IN = sel1(2);
    edges(8);
    chk("sw_act", 32'(bus.CS_ACT), 1);
    chk("sw_sel", 32'(bus.CS_SEL), 2);
    bus.CSB_IN = sel1(4);
    edges(5);
    chk("sw_noend", 32'(bus.CS_END), 0);
    edges(1);
    chk("sw_end", 32'(bus.CS_END), 1);
    chk("sw_err", 32'(bus.CS_ERR), 1);
    chk("sw_fault", 32'(bus.CS_ACT), 0);
    edges(6);
    chk("sw_hold_sel", 32'(bus.CS_SEL), 2);
    chk("sw_hold_txn", 32'(bus.TXN_CNT), 2);
    bus.CSB_IN = '1;
    edges(8);
    bus.CSB_IN = sel1(4);
    edges(6);
    chk("sw_restart", 32'(bus.CS_START), 1);
    chk("sw_sel4", 32'(bus.CS_SEL), 4);
    chk("sw_txn3", 32'(bus.TXN_CNT), 3);
    bus.CSB_IN = '1;
    edges(8);
    bus.ERR_CLR = 1'b1;
    edges(1);
    bus.ERR_CLR = 1'b0;

    // Counter wrap.
    force dut.r_txn_cnt = 16'hFFFF;
    m_txn = 16'hFFFF;
    edges(1);
    release dut.r_txn_cnt;
    edges(1);
    chk("wr_pre", 32'(bus.TXN_CNT), 32'hFFFF);
    bus.CSB_IN = sel1(31);
    edges(6);
    chk("wr_txn", 32'(bus.TXN_CNT), 0);
    chk("wr_sel", 32'(bus.CS_SEL), 31);
    bus.CSB_IN = '1;
    edges(8);

    // Reset during a selection on line 9.
    bus.CSB_IN = sel1(9);
    edges(8);
    chk("rs_act", 32'(bus.CS_ACT), 1);
    RESET = 1'b1;
    #1;
    chk("rs_act0", 32'(bus.CS_ACT), 0);
    chk("rs_sel0", 32'(bus.CS_SEL), 0);
    chk("rs_txn0", 32'(bus.TXN_CNT), 0);
    chk("rs_end0", 32'(bus.CS_END), 0);
    edges(2);
    RESET = 1'b0;
    edges(5);
    chk("rs_nostart", 32'(bus.CS_START), 0);
    chk("rs_noend", 32'(bus.CS_END), 0);
    edges(1);
    chk("rs_start", 32'(bus.CS_START), 1);
    chk("rs_sel9", 32'(bus.CS_SEL), 9);
    chk("rs_txn1", 32'(bus.TXN_CNT), 1);
    bus.CSB_IN = '1;
    edges(8);

    // Random patterns, checked by the model every cycle.
    repeat (150) begin
      r = $urandom_range(0, 5);
      a = $urandom_range(0, N - 1);
      b = $urandom_range(0, N - 1);
      if (b == a) b = (a + 1) % N;
      case (r)
        0, 1: v = '1;
        2, 3: v = sel1(a);
        4: begin
          v = sel1(a);
          v[b] = 1'b0;
        end
        default: v = N'($urandom);
      endcase
      bus.CSB_IN = v;
      bus.ERR_CLR = ($urandom_range(0, 5) == 0);
      edges($urandom_range(0, 8));
    end
    bus.CSB_IN = '1;
    bus.ERR_CLR = 1'b0;
    edges(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
